// File: rtl/load_store_unit_if.sv
// Pipeline and data-memory signal bundle for the load/store unit.
// master: the LSU side (drives rdata/done/stall/misalign and the memory
//   address, write data and enables). slave: pipeline plus memory side
//   (drives the request fields and the combinational read word).
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_i;
    logic              we_i;
    logic [1:0]        size_i;
    logic              sign_i;
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       wdata_i;
    logic [31:0]       rdata_o;
    logic              done_o;
    logic              stall_o;
    logic              misalign_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_rd_o;
    logic              mem_wr_o;
    logic [31:0]       mem_rdata_i;

    modport master (
        input  req_i, we_i, size_i, sign_i, addr_i, wdata_i,
        input  mem_rdata_i,
        output rdata_o, done_o, stall_o, misalign_o,
        output mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o
    );

    modport slave (
        output req_i, we_i, size_i, sign_i, addr_i, wdata_i,
        output mem_rdata_i,
        input  rdata_o, done_o, stall_o, misalign_o,
        input  mem_addr_o, mem_wdata_o, mem_rd_o, mem_wr_o
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a little-endian 32-bit data
// memory, sub-word stores done as read-modify-write, loads sign/zero
// extended, pipeline stalled until each access completes.
// Ports: clk_i, rst_i (async, active high), bus (load_store_unit_if.master).
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with misalign_o instead of being performed.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    load_store_unit_if.master   bus
);
    if (MEM_BYTES < 4) begin : g_bad_mem
        $error("MEM_BYTES must be at least 4");
    end

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic              we_q;
    logic              sign_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mwdata_q;
    logic [ADDR_W-1:0] maddr_q;
    logic              rd_q;
    logic              wr_q;
    logic              done_q;

    function automatic logic [31:0] extend(
        input logic [31:0] w,
        input logic [1:0]  sz,
        input logic        sg
    );
        unique case (sz)
            2'b00:   extend = {{24{sg & w[7]}}, w[7:0]};
            2'b01:   extend = {{16{sg & w[15]}}, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] w,
        input logic [31:0] d,
        input logic [1:0]  sz
    );
        unique case (sz)
            2'b00:   merge = {w[31:8], d[7:0]};
            2'b01:   merge = {w[31:16], d[15:0]};
            default: merge = d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic misal;
    logic mis_q;
    assign misal = (bus.size_i == 2'b01 && bus.addr_i[0])
                 || (bus.size_i[1] && bus.addr_i[1:0] != 2'b00);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            sign_q   <= 1'b0;
            size_q   <= 2'b00;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mwdata_q <= '0;
            maddr_q  <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        sign_q  <= bus.sign_i;
                        size_q  <= bus.size_i;
                        wdata_q <= bus.wdata_i;
                        maddr_q <= bus.addr_i;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (misal) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                            if (!bus.we_i) rdata_q <= '0;
                        end else
`endif
                        if (bus.we_i && bus.size_i[1]) begin
                            state    <= WR;
                            wr_q     <= 1'b1;
                            mwdata_q <= bus.wdata_i;
                        end else begin
                            state <= RD;
                            rd_q  <= 1'b1;
                        end
                    end
                end
                RD: begin
                    rd_q <= 1'b0;
                    if (we_q) begin
                        state    <= WR;
                        wr_q     <= 1'b1;
                        mwdata_q <= merge(bus.mem_rdata_i, wdata_q, size_q);
                    end else begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        rdata_q <= extend(bus.mem_rdata_i, size_q, sign_q);
                    end
                end
                WR: begin
                    wr_q   <= 1'b0;
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: begin
                    done_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_q  <= 1'b0;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IDLE stalls only while a request is pending; gated by reset so all
    // outputs read zero while rst_i is held.
    assign bus.stall_o = !rst_i && ((state == IDLE) ? bus.req_i
                       : (state == RD || state == WR));

    assign bus.rdata_o     = rdata_q;
    assign bus.done_o      = done_q;
    assign bus.mem_addr_o  = maddr_q;
    assign bus.mem_wdata_o = mwdata_q;
    assign bus.mem_rd_o    = rd_q;
    assign bus.mem_wr_o    = wr_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign bus.misalign_o  = mis_q;
`else
    assign bus.misalign_o  = 1'b0;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random
// accesses checked against a byte-array reference memory.
module tb_load_store_unit;
    logic clk;
    logic rst_i;
    int   passed;
    int   total;
    logic [31:0] last_rd;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];

    load_store_unit_if #(.ADDR_W(32)) bus();

    load_store_unit #(.ADDR_W(32), .MEM_BYTES(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        logic [4:0] ix;
        bus.mem_rdata_i = '0;
        for (int k = 0; k < 4; k++) begin
            ix = 5'(bus.mem_addr_o + 32'(k));
            bus.mem_rdata_i[8*k +: 8] = mem[ix];
        end
    end

    always @(posedge clk) begin
        if (bus.mem_wr_o) begin
            for (int k = 0; k < 4; k++)
                mem[5'(bus.mem_addr_o + 32'(k))] = bus.mem_wdata_o[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++)
            w[8*k +: 8] = ref_mem[(int'(a) + k) % 32];
        return w;
    endfunction

    task automatic preload(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            mem[(a + k) % 32]     = w[8*k +: 8];
            ref_mem[(a + k) % 32] = w[8*k +: 8];
        end
    endtask

    task automatic access(input logic we, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int nb, el, erd, ewr, cyc, nrd, nwr, ovl, v;
        bit mis, seen;
        logic [31:0] ew, er, wword, rdv;
        logic got_mis, st_done;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`endif
        if (mis)           begin el = 1; erd = 0; ewr = 0; end
        else if (!we)      begin el = 2; erd = 1; ewr = 0; end
        else if (nb == 4)  begin el = 2; erd = 0; ewr = 1; end
        else               begin el = 3; erd = 1; ewr = 1; end
        if (we && !mis)
            for (int k = 0; k < nb; k++)
                ref_mem[(int'(a) + k) % 32] = wd[8*k +: 8];
        ew = ref_word(a);
        if (we) er = last_rd;
        else if (mis) er = 0;
        else begin
            if (nb == 1) begin
                v = int'(ew & 32'hFF);
                if (sg && v >= 128) v -= 256;
            end else if (nb == 2) begin
                v = int'(ew & 32'hFFFF);
                if (sg && v >= 32768) v -= 65536;
            end else v = int'(ew);
            er = 32'(v);
        end
        if (!we) last_rd = er;

        @(negedge clk);
        bus.req_i = 1'b1; bus.we_i = we; bus.size_i = sz;
        bus.sign_i = sg; bus.addr_i = a; bus.wdata_i = wd;
        #1 check({tag, "/stall_req"}, 32'(bus.stall_o), 1);
        @(posedge clk); #1;
        bus.req_i = 1'b0; bus.we_i = 1'($urandom);
        bus.size_i = 2'($urandom); bus.sign_i = 1'($urandom);
        bus.addr_i = $urandom; bus.wdata_i = $urandom;
        cyc = 0; nrd = 0; nwr = 0; ovl = 0; seen = 0;
        wword = '0; rdv = '0; got_mis = 1'b0; st_done = 1'b1;
        while (!seen && cyc < 8) begin
            @(negedge clk); cyc++;
            if (bus.mem_rd_o) nrd++;
            if (bus.mem_wr_o) begin nwr++; wword = bus.mem_wdata_o; end
            if (bus.mem_rd_o || bus.mem_wr_o)
                check({tag, "/maddr"}, bus.mem_addr_o, a);
            if (bus.mem_rd_o && bus.mem_wr_o) ovl++;
            if (bus.done_o) begin
                seen = 1; got_mis = bus.misalign_o;
                st_done = bus.stall_o; rdv = bus.rdata_o;
            end
        end
        check({tag, "/done_seen"}, 32'(seen), 1);
        check({tag, "/latency"}, cyc, el);
        check({tag, "/n_rd"}, nrd, erd);
        check({tag, "/n_wr"}, nwr, ewr);
        check({tag, "/overlap"}, ovl, 0);
        check({tag, "/misalign"}, 32'(got_mis), 32'(mis));
        check({tag, "/stall_done"}, 32'(st_done), 0);
        check({tag, "/rdata"}, rdv, er);
        if (we && !mis) check({tag, "/wword"}, wword, ew);
    endtask

    initial begin
        int n;
        bit seen;
        passed = 0; total = 0; last_rd = '0;
        rst_i = 1'b1;
        bus.req_i = 0; bus.we_i = 0; bus.size_i = 0; bus.sign_i = 0;
        bus.addr_i = 0; bus.wdata_i = 0;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst/rdata", bus.rdata_o, 0);
        check("rst/flags", {28'd0, bus.done_o, bus.stall_o,
                            bus.mem_rd_o, bus.mem_wr_o}, 0);
        check("rst/maddr", bus.mem_addr_o, 0);
        check("rst/mwdata", bus.mem_wdata_o, 0);
        check("rst/misalign", 32'(bus.misalign_o), 0);
        rst_i = 1'b0;

        preload(4, 32'h55667788);
        @(negedge clk);
        bus.req_i = 1; bus.we_i = 1; bus.size_i = 2'b10;
        bus.addr_i = 4; bus.wdata_i = 32'hCAFEF00D;
        @(posedge clk); #1 bus.req_i = 0;
        seen = 0; n = 0;
        while (!seen && n < 4) begin
            @(negedge clk); n++;
            if (bus.mem_wr_o) seen = 1;
        end
        check("midwr/wr_seen", 32'(seen), 1);
        rst_i = 1'b1;
        #1;
        check("midwr/flags", {28'd0, bus.done_o, bus.stall_o,
                              bus.mem_rd_o, bus.mem_wr_o}, 0);
        check("midwr/maddr", bus.mem_addr_o, 0);
        check("midwr/mwdata", bus.mem_wdata_o, 0);
        @(posedge clk);
        @(negedge clk) rst_i = 1'b0;
        last_rd = '0;
        access(0, 2'b10, 0, 4, 0, "midwr/load4");
        check("midwr/old_word", last_rd, 32'h55667788);

        access(1, 2'b10, 0, 8, 32'hDEADBEEF, "w8/store");
        access(0, 2'b10, 0, 8, 0, "w8/load");
        check("w8/value", last_rd, 32'hDEADBEEF);

        preload(12, 32'h11223344);
        access(1, 2'b00, 0, 12, 32'h000000AA, "rmw/byte");
        check("rmw/mem", {mem[15], mem[14], mem[13], mem[12]}, 32'h112233AA);

        preload(16, 32'h0000F080);
        access(0, 2'b00, 1, 16, 0, "ext/bs");
        check("ext/bs_val", last_rd, 32'hFFFFFF80);
        access(0, 2'b00, 0, 16, 0, "ext/bu");
        check("ext/bu_val", last_rd, 32'h00000080);
        access(0, 2'b01, 1, 16, 0, "ext/hs");
        check("ext/hs_val", last_rd, 32'hFFFFF080);

        access(1, 2'b10, 0, 30, 32'h01020304, "wrap/store");
        check("wrap/bytes", {mem[1], mem[0], mem[31], mem[30]}, 32'h01020304);
        access(0, 2'b10, 0, 30, 0, "wrap/load");
        check("wrap/value", last_rd, 32'h01020304);

        access(0, 2'b10, 0, 6, 0, "mis/load6");
        access(1, 2'b01, 0, 5, 32'h0000BEEF, "mis/half5");

        for (int i = 0; i < 40; i++) begin
            access(1'($urandom), 2'($urandom), 1'($urandom),
                   32'($urandom_range(0, 31)), $urandom, "rand");
        end
        for (int i = 0; i < 32; i += 4)
            check("final/mem", {mem[i+3], mem[i+2], mem[i+1], mem[i]},
                  ref_word(32'(i)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the CPU data-memory interface, sitting between the MEM pipeline stage and the byte-addressed, little-endian 32-bit data memory.
- Accepts byte, halfword and word loads and stores from the pipeline and drives the memory's address, write-data, read-enable and write-enable.
- Performs sub-word stores as read-modify-write sequences and sign- or zero-extends loads.
- Stalls the pipeline until each access completes.

Parameters:
- ADDR_W, 32, width of the request and memory address.
- MEM_BYTES, 32, data memory size in bytes; addresses wrap modulo MEM_BYTES.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_i  in  1  access request from MEM stage; held stable while stall_o=1
- we_i  in  1  1=store, 0=load
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- sign_i  in  1  loads: 1=sign-extend, 0=zero-extend
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-justified
- rdata_o  out  32  load result, extended
- done_o  out  1  one-cycle pulse when the access completes
- stall_o  out  1  freeze pipeline
- misalign_o  out  1  one-cycle pulse alongside done_o for a rejected misaligned access (feature only)
- mem_addr_o  out  ADDR_W  memory byte address
- mem_wdata_o  out  32  memory write word
- mem_rd_o  out  1  memory read enable
- mem_wr_o  out  1  memory write enable (memory writes 4 bytes at the clock edge)
- mem_rdata_i  in  32  memory read word: bytes addr..addr+3, combinational

Behaviour:
- Reset: asynchronous, applies immediately. State=IDLE; rdata_o, mem_addr_o, mem_wdata_o=0; done_o, stall_o, mem_rd_o, mem_wr_o, misalign_o=0. Reset mid-access abandons the access with no memory write.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - stall_o=req_i.
  - On req_i=1, latch we/size/sign/addr/wdata at the clock edge.
  - Next state: load → RD; word store → WR; byte or half store → RD.
- RD:
  - mem_rd_o=1, mem_addr_o=latched addr.
  - At the edge, capture mem_rdata_i.
  - Next state: load → DONE; sub-word store → WR.
- WR:
  - mem_wr_o=1, mem_addr_o=latched addr.
  - Word store: mem_wdata_o=wdata.
  - Byte store: captured word with bits[7:0] replaced by wdata[7:0].
  - Half store: captured word with bits[15:0] replaced by wdata[15:0].
  - Next state: DONE.
- DONE:
  - done_o=1 and stall_o=0 for one cycle. Next state: IDLE.
  - Loads: rdata_o holds the extended value from DONE until the next load completes.
  - Stores leave rdata_o unchanged.
- Load extension:
  - Byte: bits[7:0], extended per sign_i.
  - Half: bits[15:0], extended per sign_i.
  - Word: passed through unchanged.
- stall_o=1 in RD and WR, and in IDLE whenever req_i=1. No new request is sampled in DONE; a back-to-back request is accepted in the following IDLE cycle.
- mem_rd_o and mem_wr_o are never both 1. Both are 0 in IDLE and DONE.
- Latency from acceptance edge to done_o: load 2 cycles, word store 2 cycles, sub-word store 3 cycles.
- Address wrap: mem_addr_o is passed as latched; the memory wraps bytes modulo MEM_BYTES (addr 30 word touches bytes 30,31,0,1). The RMW preserves the wrapped bytes.
- Changing req_i or its fields while stall_o=1 has no effect after latching.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, goes IDLE→DONE with no mem_rd_o/mem_wr_o. misalign_o=1 with done_o; rdata_o=0 for loads.
- Undefined: misalign_o tied 0. Misaligned accesses proceed normally, since the memory handles unaligned byte addresses.

Test Plan:
- Reset: assert rst_i mid-WR of a word store to addr 4 (mem_wr_o=1) → outputs 0 within the same cycle; bytes 4..7 unchanged on a later word load.
- Word store then load: store 0xDEADBEEF @8, load word @8 → rdata_o=0xDEADBEEF, done_o on cycle 2 of each, no overlap of mem_rd_o/mem_wr_o.
- Byte RMW: memory @12=0x11223344, store byte 0xAA @12 → one RD then one WR with mem_wdata_o=0x112233AA; done_o 3 cycles after acceptance.
- Load extension: memory @16=0x0000F080. Byte signed → 0xFFFFFF80; byte unsigned → 0x00000080; half signed → 0xFFFFF080.
- Wrap: store word 0x01020304 @30 → byte 30=0x04, byte 31=0x03, byte 0=0x02, byte 1=0x01; load word @30 returns 0x01020304.
- Misalign (feature on): load word @6 → done_o=misalign_o=1 after 1 cycle, rdata_o=0, no mem_rd_o. Feature off: same load returns bytes 6..9.
